// File: rtl/q_state_pkg.sv
// Shared types for the q_state_output write path.
package q_state_pkg;

  localparam int Q_OUT_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [63:0] re;
    logic [63:0] im;
  } cplx_t;

endpackage

// File: rtl/q_out_addr_gen.sv
// Address generator: latched base plus running index, with a countdown of words still owed.
module q_out_addr_gen
  import q_state_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              empty
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  remaining;

  // Base/count are captured only on load, so they stay fixed for the whole job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base      <= '0;
      idx       <= '0;
      remaining <= '0;
    end else if (clear) begin
      idx       <= '0;
      remaining <= '0;
    end else if (load) begin
      base      <= base_in;
      idx       <= '0;
      remaining <= count_in;
    end else if (step && (remaining != '0)) begin
      idx       <= idx + ADDR_W'(1);
      remaining <= remaining - CNT_W'(1);
    end
  end

  // The sum truncates to ADDR_W bits, which gives the silent address wrap.
  assign addr  = base + idx;
  assign last  = (remaining == CNT_W'(1));
  assign empty = (remaining == '0);

endmodule

// File: rtl/q_state_output_writer.sv
// Write-side engine for the q_state_output SRAM: packs complex results and streams them to memory.
module q_state_output_writer
  import q_state_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = Q_OUT_DATA_W,
  parameter int HALF_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_real,
  input  logic [HALF_W-1:0] in_imag,
  output logic              busy,
  output logic              done,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data
);

  wr_state_e         state;
  wr_state_e         state_next;
  logic              accept;
  logic              load;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;
  logic              gen_empty;
  cplx_t             word_in;

  assign in_ready = (state == WRITE) && !gen_empty;
  assign accept   = in_valid && in_ready;
  assign load     = start && (state == IDLE) && !flush;
  assign word_in  = '{re: in_real, im: in_imag};

  q_out_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .clear    (flush),
    .step     (accept),
    .base_in  (base_addr),
    .count_in (word_count),
    .addr     (gen_addr),
    .last     (gen_last),
    .empty    (gen_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything, including a coincident start.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = (word_count != '0) ? WRITE : DONE;
          end
        end
        WRITE: begin
          if (accept && gen_last) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == WRITE) || (state == DONE);
  assign done = (state == DONE);

  // One-cycle write register: an accepted word becomes an SRAM write at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_write_enable  <= 1'b0;
      sram_write_address <= '0;
      sram_write_data    <= '0;
    end else begin
      sram_write_enable <= accept;
      if (accept) begin
        sram_write_address <= gen_addr;
        sram_write_data    <= DATA_W'(word_in);
      end
    end
  end

endmodule

// File: tb/tb_q_state_output_writer.sv
// Directed self-checking bench for q_state_output_writer.
module tb_q_state_output_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [11:0]  base_addr;
  logic [15:0]  word_count;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_real;
  logic [63:0]  in_imag;
  logic         busy;
  logic         done;
  logic         sram_write_enable;
  logic [11:0]  sram_write_address;
  logic [127:0] sram_write_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  q_state_output_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .base_addr          (base_addr),
    .word_count         (word_count),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_real            (in_real),
    .in_imag            (in_imag),
    .busy               (busy),
    .done               (done),
    .sram_write_enable  (sram_write_enable),
    .sram_write_address (sram_write_address),
    .sram_write_data    (sram_write_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic exp_we, input logic exp_busy,
                              input logic exp_done, input logic exp_ready);
    check({tag, ".we"},    128'(sram_write_enable), 128'(exp_we));
    check({tag, ".busy"},  128'(busy),              128'(exp_busy));
    check({tag, ".done"},  128'(done),              128'(exp_done));
    check({tag, ".ready"}, 128'(in_ready),          128'(exp_ready));
  endtask

  task automatic check_write(input string tag, input logic [11:0] exp_addr, input logic [127:0] exp_data);
    check({tag, ".addr"}, 128'(sram_write_address), 128'(exp_addr));
    check({tag, ".data"}, sram_write_data,          exp_data);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_job(input logic [11:0] base, input logic [15:0] count);
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    step();
    start      = 1'b0;
    base_addr  = 12'h5A5;
    word_count = 16'hFFFF;
  endtask

  logic [11:0] t3_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
  logic        t2_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [11:0] t2_addr [5]  = '{12'h010, 12'h010, 12'h011, 12'h011, 12'h012};
  int          strobes;
  int          acc;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_real    = '0;
    in_imag    = '0;

    #12;
    check_output("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_write("rst", 12'h000, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_output("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // T1: four back-to-back words from base 0
    $display("[TB] T1 back-to-back");
    begin_job(12'h000, 16'd4);
    check_output("t1.go", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_real  = 64'(i);
      in_imag  = ~64'(i);
      step();
      check_write($sformatf("t1.w%0d", i), 12'(i), {64'(i), ~64'(i)});
      check_output($sformatf("t1.c%0d", i), 1'b1, 1'b1, i == 3, i != 3);
    end
    in_valid = 1'b0;
    step();
    check_output("t1.end", 1'b0, 1'b0, 1'b0, 1'b0);
    check_write("t1.hold", 12'h003, {64'd3, ~64'd3});

    // T2: gapped valid, three words
    $display("[TB] T2 gapped valid");
    begin_job(12'h010, 16'd3);
    strobes = 0;
    acc     = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = t2_valid[i];
      in_real  = 64'hC000_0000_0000_0000 | 64'(i);
      in_imag  = 64'h7FF8_0000_0000_0000 | 64'(i);
      step();
      if (t2_valid[i]) acc++;
      if (sram_write_enable) strobes++;
      check($sformatf("t2.we%0d", i), 128'(sram_write_enable), 128'(t2_valid[i]));
      check($sformatf("t2.a%0d", i), 128'(sram_write_address), 128'(t2_addr[i]));
      check($sformatf("t2.rdy%0d", i), 128'(in_ready), 128'(acc < 3));
    end
    check("t2.data", sram_write_data, {64'hC000_0000_0000_0004, 64'h7FF8_0000_0000_0004});
    check("t2.done", 128'(done), 128'(1'b1));
    in_valid = 1'b1;
    step();
    check("t2.strobes", 128'(strobes), 128'(3));
    check_output("t2.end", 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;

    // T3: address wrap
    $display("[TB] T3 wrap");
    begin_job(12'hFFE, 16'd4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_real  = 64'h3FF0_0000_0000_0000;
      in_imag  = 64'hBFF0_0000_0000_0000 + 64'(i);
      step();
      check_write($sformatf("t3.w%0d", i), t3_addr[i],
                  {64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000 + 64'(i)});
    end
    check("t3.done", 128'(done), 128'(1'b1));
    in_valid = 1'b0;
    step();

    // T4: zero-length job
    $display("[TB] T4 zero count");
    in_valid = 1'b1;
    begin_job(12'h123, 16'd0);
    check_output("t4.done", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check_output("t4.end", 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;

    // T5: flush after two of five words, then flush+start collision, then a fresh job
    $display("[TB] T5 flush");
    begin_job(12'h100, 16'd5);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_real  = 64'hAAAA_0000_0000_0000 | 64'(i);
      in_imag  = 64'h5555_0000_0000_0000 | 64'(i);
      step();
      check_write($sformatf("t5.w%0d", i), 12'h100 + 12'(i),
                  {64'hAAAA_0000_0000_0000 | 64'(i), 64'h5555_0000_0000_0000 | 64'(i)});
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    check_output("t5.flush", 1'b0, 1'b0, 1'b0, 1'b0);
    start      = 1'b1;
    base_addr  = 12'h777;
    word_count = 16'd2;
    step();
    check_output("t5.collide", 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    start = 1'b0;
    begin_job(12'h200, 16'd1);
    in_valid = 1'b1;
    in_real  = 64'h0123_4567_89AB_CDEF;
    in_imag  = 64'hFEDC_BA98_7654_3210;
    step();
    check_write("t5.new", 12'h200, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
    check_output("t5.newc", 1'b1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();

    // T6: asynchronous reset between edges, then a normal job
    $display("[TB] T6 async reset");
    begin_job(12'h300, 16'd4);
    in_valid = 1'b1;
    in_real  = 64'h1111_1111_1111_1111;
    in_imag  = 64'h2222_2222_2222_2222;
    step();
    check_write("t6.pre", 12'h300, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222});
    #2;
    reset = 1'b1;
    #1;
    check_output("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_write("t6.rst", 12'h000, 128'h0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    begin_job(12'h050, 16'd2);
    in_valid = 1'b1;
    in_real  = 64'h4009_21FB_5444_2D18;
    in_imag  = 64'h8000_0000_0000_0000;
    step();
    check_write("t6.w0", 12'h050, {64'h4009_21FB_5444_2D18, 64'h8000_0000_0000_0000});
    check_output("t6.c0", 1'b1, 1'b1, 1'b0, 1'b1);
    in_real = 64'hFFF0_0000_0000_0001;
    in_imag = 64'h0000_0000_0000_0001;
    step();
    check_write("t6.w1", 12'h051, {64'hFFF0_0000_0000_0001, 64'h0000_0000_0000_0001});
    check_output("t6.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    check_output("t6.end", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
